piso_tx: RTL
============

Name: piso_tx

Overview:
Parallel-in/serial-out transmitter. It is the sending end of the single-bit serial data line that our D-flip-flop-based receivers sample. It accepts a parallel word through a valid/ready handshake and shifts it out one bit per clock, with an optional even-parity bit appended. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 8, data word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
PARITY_EN, 0, 1 = append one even-parity bit after the data bits (frame = WIDTH+1 bits); 0 = frame is WIDTH bits.

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-low reset (0 = reset asserted).
load_valid  input  1  load_data is valid this cycle.
load_data  input  WIDTH  word to transmit.
load_ready  output  1  transmitter can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a frame bit this cycle.
sout_first  output  1  sout carries the first bit of a frame.
busy  output  1  frame in progress (same as sout_valid).
done  output  1  one-cycle pulse in the cycle after a frame's last bit.

Behaviour:
- Reset: rst low asynchronously forces state IDLE, shift register 0, bit counter 0, and done 0. Resulting outputs: sout 0, sout_valid 0, sout_first 0, busy 0, load_ready 1. This holds for the whole time rst is low. Reset in mid-frame discards the frame; no done pulse is produced for it.
- Frame length: FL = WIDTH + PARITY_EN. The bit counter counts bits remaining after the current bit, FL-1 down to 0, and is sized for FL.
- States: IDLE and SHIFT.
- Accept: a transfer occurs at a posedge where load_valid and load_ready are both 1. load_ready = (state==IDLE) or (state==SHIFT and counter==0).
- On accept:
  - Capture load_data into the shift register.
  - If PARITY_EN, capture the parity bit as XOR of all data bits.
  - Load the counter with FL-1 and go to SHIFT.
- Latency: the first frame bit appears on sout in the cycle immediately after the accepting edge.
- Outputs in SHIFT:
  - sout = shift-register MSB when MSB_FIRST, else LSB. The parity bit follows the last data bit.
  - sout_valid = busy = 1.
  - sout_first = 1 only while counter == FL-1.
- All outputs are driven from registers only. No combinational path exists from load_* to sout*.
- Each posedge in SHIFT:
  - If counter != 0: shift toward the output end, decrement the counter, and ignore load_valid.
  - If counter == 0 (last bit): set done to 1 for the next cycle. Then:
    - if load_valid, accept the new word and stay in SHIFT, giving a gapless frame;
    - otherwise go to IDLE.
- done is a single-cycle pulse in the cycle after the last bit. It also pulses when the next frame begins in that same cycle.
- load_data is don't-care when not accepted. A word held with load_valid while busy stays pending until load_ready rises; it is not lost and not duplicated.
- Ports are 2-state; no X on any output after reset release.
- Inline assertions required:
  - rst low implies !sout_valid;
  - sout_valid runs exactly FL consecutive cycles per accept;
  - done implies a last bit in the previous cycle.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, PARITY_EN=0: accept 0xA5 at edge T.
   - sout = 1,0,1,0,0,1,0,1 in cycles T+1..T+8, with sout_first only at T+1.
   - done=1 at T+9; load_ready=1 at T+8.
   - sout_valid=0 at T+9.
2. Hold load_valid with 0xA5 then 0x3C: 16 contiguous sout_valid cycles.
   - Bits are 10100101 followed by 00111100.
   - sout_first at bits 1 and 9; done pulses at bit 9's cycle and after bit 16.
3. MSB_FIRST=0: accept 0x01 → sout = 1 then seven 0s. Accept 0x80 → seven 0s then 1.
4. PARITY_EN=1: 0x07 → 9-bit frame 00000111 followed by parity 1. 0x03 → parity bit 0. done after the 9th bit.
5. Drive rst low asynchronously (between edges) after 3 bits of 0xFF.
   - sout, sout_valid, and busy go to 0 immediately; no done pulse.
   - After release, load_ready=1 and a new 0x55 transmits correctly.
6. Raise load_valid with 0x12 at bit 2 of a running frame:
   - load_ready stays 0 until the last bit; 0x12 is accepted exactly once at that edge.
   - 0x12 follows with no gap.

Source files
------------

// File: rtl/piso_tx.sv
// Serial transmitter: first frame bit on sout the cycle after accept; optional even parity bit last.
// load_ready only while idle or on the last frame bit, so a held word waits and then streams with no gap.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_first,
    output logic             busy,
    output logic             done
);
    localparam int FL = WIDTH + ((PARITY_EN != 0) ? 1 : 0);
    localparam int CW = $clog2(FL);
    localparam logic [CW-1:0] CNT_TOP = CW'(FL - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q;
    logic [FL-1:0]   sr_q;
    logic [CW-1:0]   cnt_q;
    logic            done_q;
    logic [FL-1:0]   frame_d;
    logic [FL-1:0]   shift_d;

    // The parity bit sits at the far end of the register so it leaves after the last data bit.
    if (PARITY_EN != 0) begin : g_par
        if (MSB_FIRST != 0) begin : g_msb
            assign frame_d = {load_data, ^load_data};
        end else begin : g_lsb
            assign frame_d = {^load_data, load_data};
        end
    end else begin : g_nopar
        assign frame_d = load_data;
    end

    assign shift_d = (MSB_FIRST != 0) ? (sr_q << 1) : (sr_q >> 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_valid) begin
                        sr_q    <= frame_d;
                        cnt_q   <= CNT_TOP;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        sr_q  <= shift_d;
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        done_q <= 1'b1;
                        if (load_valid) begin
                            sr_q  <= frame_d;
                            cnt_q <= CNT_TOP;
                        end else begin
                            sr_q    <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sout       = (MSB_FIRST != 0) ? sr_q[FL-1] : sr_q[0];
    assign sout_valid = (state_q == SHIFT);
    assign busy       = sout_valid;
    assign sout_first = (state_q == SHIFT) && (cnt_q == CNT_TOP);
    assign load_ready = (state_q == IDLE) || (cnt_q == '0);
    assign done       = done_q;

`ifndef SYNTHESIS
    // Length of the current valid run, cleared on idle and restarted on each frame's first bit.
    int unsigned run_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            run_q <= 0;
        else if (sout_valid) run_q <= sout_first ? 1 : run_q + 1;
        else                 run_q <= 0;
    end

    a_rst_quiet: assert property (@(posedge clk) !rst |-> !sout_valid);
    a_run_len:   assert property (@(posedge clk) disable iff (!rst)
                     (run_q != 0 && (!sout_valid || sout_first)) |-> run_q == FL);
    a_run_max:   assert property (@(posedge clk) disable iff (!rst)
                     (sout_valid && !sout_first) |-> (run_q != 0 && run_q < FL));
    a_done_last: assert property (@(posedge clk) disable iff (!rst)
                     done |-> $past(sout_valid && cnt_q == '0));
`endif
endmodule
